// File: rtl/spi_pin_bank_if.sv
// APB3 bus bundle for spi_pin_bank.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : requester -> pin bank
//   PRDATA/PREADY/PSLVERR            : pin bank -> requester
interface spi_pin_bank_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/spi_pin_bank.sv
// spi_pin_bank: APB3 slave driving NPINS active-low control pins, with
// atomic set/clear/toggle, a one-pin timed pulse engine and a sticky
// done flag with interrupt.
//   PCLK, PRESERN : clock, synchronous active-high reset
//   bus           : APB3 slave port (registered PRDATA, zero wait states)
//   PINS          : registered pin outputs
//   IRQ           : registered done & ie

// One pin: holds its OUT bit and the registered pin driver.
module spi_pin_lane #(
  parameter logic RST = 1'b1
) (
  input  logic PCLK,
  input  logic PRESERN,
  input  logic wr_out,
  input  logic wr_set,
  input  logic wr_clr,
  input  logic wr_tog,
  input  logic wd,
  input  logic ovr,     // pulse owns this pin in the next cycle
  input  logic lvl,
  output logic out_q,
  output logic pin
);
  logic out_n;

  always_comb begin
    out_n = out_q;
    if (wr_out)            out_n = wd;
    else if (wr_set && wd) out_n = 1'b1;
    else if (wr_clr && wd) out_n = 1'b0;
    else if (wr_tog && wd) out_n = ~out_q;
  end

  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      out_q <= RST;
      pin   <= RST;
    end else begin
      out_q <= out_n;
      pin   <= ovr ? lvl : out_n;
    end
  end
endmodule

module spi_pin_bank #(
  parameter int               NPINS     = 8,
  parameter logic [NPINS-1:0] RESET_VAL = '1,
  parameter int               CNT_W     = 16
) (
  input  logic             PCLK,
  input  logic             PRESERN,
  spi_pin_bank_if.slave    bus,
  output logic [NPINS-1:0] PINS,
  output logic             IRQ
);
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  localparam logic [2:0] A_OUT = 3'd0, A_SET = 3'd1, A_CLR = 3'd2, A_TOG = 3'd3,
                         A_LEN = 3'd4, A_PUL = 3'd5, A_STA = 3'd6, A_RSV = 3'd7;

  state_t           state;
  logic [CNT_W-1:0] cnt_q, len_q;
  logic [7:0]       idx_q, idx_n;
  logic             lvl_q, lvl_n;
  logic             done_q, done_n, ie_q, ie_n;
  logic [31:0]      prdata_q, rdata;
  logic [NPINS-1:0] out_q;

  logic [2:0] a;
  logic       wr, rd_cap, acc, busy, idx_bad, err, wr_ok;
  logic       pul_wr, start, rel, act_n;

  assign a       = bus.PADDR[4:2];
  assign wr      = bus.PSEL & bus.PENABLE & bus.PWRITE;
  assign rd_cap  = bus.PSEL & ~bus.PENABLE & ~bus.PWRITE;
  assign acc     = bus.PSEL & bus.PENABLE;
  assign busy    = (state == S_ACTIVE);
  assign idx_bad = bus.PWDATA[7:0] >= 8'(NPINS);

  assign err   = acc & ((a == A_RSV) |
                        (bus.PWRITE & (a == A_PUL) & (idx_bad | busy)));
  assign wr_ok = wr & ~err;

  // LEN = 0 pulses are accepted but never leave IDLE
  assign pul_wr = wr_ok & (a == A_PUL);
  assign start  = pul_wr & (len_q != '0);
  assign rel    = busy & (cnt_q == CNT_W'(1));
  assign act_n  = start | (busy & ~rel);

  assign idx_n = pul_wr ? bus.PWDATA[7:0] : idx_q;
  assign lvl_n = pul_wr ? bus.PWDATA[8]   : lvl_q;
  assign ie_n  = (wr_ok & (a == A_STA)) ? bus.PWDATA[2] : ie_q;

  // A release on the same edge as a W1C keeps done set
  always_comb begin
    done_n = done_q;
    if (rel)                                       done_n = 1'b1;
    else if (wr_ok && a == A_STA && bus.PWDATA[1]) done_n = 1'b0;
  end

  always_comb begin
    rdata = '0;
    case (a)
      A_OUT:   rdata = 32'(out_q);
      A_LEN:   rdata = 32'(len_q);
      A_PUL:   rdata = {23'd0, lvl_q, idx_q};
      A_STA:   rdata = {29'd0, ie_q, done_q, busy};
      default: rdata = '0;
    endcase
  end

  assign bus.PRDATA  = prdata_q;
  assign bus.PREADY  = 1'b1;
  assign bus.PSLVERR = err;

  // Pins decide from next-state values so the override lands on the
  // accept edge and drops on the release edge.
  for (genvar i = 0; i < NPINS; i++) begin : g_lane
    spi_pin_lane #(.RST(RESET_VAL[i])) u_lane (
      .PCLK   (PCLK),
      .PRESERN(PRESERN),
      .wr_out (wr_ok & (a == A_OUT)),
      .wr_set (wr_ok & (a == A_SET)),
      .wr_clr (wr_ok & (a == A_CLR)),
      .wr_tog (wr_ok & (a == A_TOG)),
      .wd     (bus.PWDATA[i]),
      .ovr    (act_n & (idx_n == 8'(i))),
      .lvl    (lvl_n),
      .out_q  (out_q[i]),
      .pin    (PINS[i])
    );
  end

  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state    <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      lvl_q    <= 1'b0;
      done_q   <= 1'b0;
      ie_q     <= 1'b0;
      IRQ      <= 1'b0;
      prdata_q <= '0;
    end else begin
      if (wr_ok && a == A_LEN) len_q <= bus.PWDATA[CNT_W-1:0];
      if (rd_cap)              prdata_q <= rdata;
      idx_q  <= idx_n;
      lvl_q  <= lvl_n;
      done_q <= done_n;
      ie_q   <= ie_n;
      IRQ    <= done_n & ie_n;
      case (state)
        S_IDLE: if (start) begin
          state <= S_ACTIVE;
          cnt_q <= len_q;
        end
        S_ACTIVE: begin
          if (rel) state <= S_IDLE;
          else     cnt_q <= cnt_q - CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.PADDR[31:5], bus.PADDR[1:0], bus.PWDATA};
endmodule

// File: tb/tb_spi_pin_bank.sv
// Directed bench for spi_pin_bank (NPINS=8, CNT_W=16): register access,
// pulse timing, error responses, pulse-time OUT writes and mid-pulse reset.
module tb_spi_pin_bank;
  logic       PCLK = 1'b0;
  logic       PRESERN = 1'b1;
  logic [7:0] PINS;
  logic       IRQ;
  int         n_chk = 0, n_err = 0;
  logic [31:0] rd;
  logic        e;

  spi_pin_bank_if bus();

  spi_pin_bank #(.NPINS(8), .RESET_VAL(8'hFF), .CNT_W(16)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .bus(bus.slave), .PINS(PINS), .IRQ(IRQ));

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns at the negedge after the access edge.
  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data, output logic err);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = addr; bus.PWDATA = data;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1 err = bus.PSLVERR;
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1 err = bus.PSLVERR;
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    data = bus.PRDATA;
  endtask

  initial begin
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b0;
    @(negedge PCLK);
    check("rst_pins",   32'(PINS), 32'hFF);
    check("rst_prdata", bus.PRDATA, 32'h0);
    check("rst_irq",    32'(IRQ), 32'h0);
    check("pready",     32'(bus.PREADY), 32'h1);
    apb_rd(32'h00, rd, e); check("rst_out", rd, 32'hFF);
    apb_rd(32'h18, rd, e); check("rst_status", rd, 32'h0);

    // OUT / SET / CLR / TOG
    apb_wr(32'h00, 32'hA5, e); check("out_pins", 32'(PINS), 32'hA5); check("out_err", 32'(e), 0);
    apb_wr(32'h04, 32'h02, e); check("set_pins", 32'(PINS), 32'hA7);
    apb_wr(32'h08, 32'h80, e); check("clr_pins", 32'(PINS), 32'h27);
    apb_wr(32'h0C, 32'h0F, e); check("tog_pins", 32'(PINS), 32'h28);
    apb_rd(32'h04, rd, e); check("rd_set", rd, 0);
    apb_rd(32'h08, rd, e); check("rd_clr", rd, 0);
    apb_rd(32'h0C, rd, e); check("rd_tog", rd, 0);
    apb_rd(32'h00, rd, e); check("rd_out", rd, 32'h28);

    // Pulse: LEN=5 on pin 3, lvl 0, ie=1
    apb_wr(32'h00, 32'hFF, e);
    apb_wr(32'h10, 32'd5, e);
    apb_wr(32'h18, 32'h4, e);
    apb_rd(32'h10, rd, e); check("rd_len", rd, 5);
    apb_wr(32'h14, 32'h003, e); check("p1_err", 32'(e), 0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("p1_pin_c%0d", k), 32'(PINS), 32'hF7);
      check($sformatf("p1_irq_c%0d", k), 32'(IRQ), 0);
      @(negedge PCLK);
    end
    check("p1_rel_pins", 32'(PINS), 32'hFF);
    check("p1_rel_irq",  32'(IRQ), 1);
    apb_rd(32'h18, rd, e); check("p1_status", rd, 32'h6);
    apb_wr(32'h18, 32'h6, e); check("p1_w1c_irq", 32'(IRQ), 0);
    apb_rd(32'h18, rd, e); check("p1_status2", rd, 32'h4);

    // Errors: pulse while busy, bad idx, reserved address, LEN=0
    apb_wr(32'h10, 32'd10, e);
    apb_wr(32'h14, 32'h002, e); check("p2_err", 32'(e), 0);
    apb_rd(32'h18, rd, e); check("p2_busy", rd, 32'h5);
    apb_wr(32'h14, 32'h005, e); check("busy_err", 32'(e), 1);
    check("busy_pins", 32'(PINS), 32'hFB);
    apb_rd(32'h14, rd, e); check("busy_pulse_rd", rd, 32'h002);
    repeat (10) @(negedge PCLK);
    check("p2_rel_pins", 32'(PINS), 32'hFF);
    apb_rd(32'h18, rd, e); check("p2_status", rd, 32'h6);
    apb_wr(32'h18, 32'h6, e);
    apb_wr(32'h14, 32'h008, e); check("idx8_err", 32'(e), 1);
    check("idx8_pins", 32'(PINS), 32'hFF);
    apb_rd(32'h14, rd, e); check("idx8_pulse_rd", rd, 32'h002);
    apb_wr(32'h1C, 32'h1, e); check("rsv_wr_err", 32'(e), 1);
    apb_rd(32'h1C, rd, e); check("rsv_rd_err", 32'(e), 1);
    apb_rd(32'h00, rd, e); check("ok_rd_err", 32'(e), 0);
    apb_wr(32'h10, 32'd0, e);
    apb_wr(32'h14, 32'h001, e); check("len0_err", 32'(e), 0);
    check("len0_pins", 32'(PINS), 32'hFF);
    apb_rd(32'h18, rd, e); check("len0_status", rd, 32'h4);

    // OUT[3] cleared during lvl=1 pulse; W1C lands on the release edge
    apb_wr(32'h10, 32'd6, e);
    apb_wr(32'h14, 32'h103, e); check("p3_err", 32'(e), 0);
    check("p3_pins", 32'(PINS), 32'hFF);
    apb_wr(32'h08, 32'h08, e); check("p3_clr_pins", 32'(PINS), 32'hFF);
    apb_wr(32'h18, 32'h6, e);
    check("p3_rel_pins", 32'(PINS), 32'hF7);
    check("p3_irq", 32'(IRQ), 1);
    apb_rd(32'h18, rd, e); check("p3_done_kept", rd, 32'h6);
    apb_rd(32'h14, rd, e); check("p3_pulse_rd", rd, 32'h103);

    // Reset mid-pulse
    apb_wr(32'h10, 32'd20, e);
    apb_wr(32'h14, 32'h000, e); check("p4_pins", 32'(PINS), 32'hF6);
    PRESERN = 1'b1;
    @(negedge PCLK);
    PRESERN = 1'b0;
    check("mid_rst_pins", 32'(PINS), 32'hFF);
    check("mid_rst_irq",  32'(IRQ), 0);
    apb_rd(32'h18, rd, e); check("mid_rst_status", rd, 0);
    apb_rd(32'h10, rd, e); check("mid_rst_len", rd, 0);
    apb_rd(32'h00, rd, e); check("mid_rst_out", rd, 32'hFF);
    apb_rd(32'h14, rd, e); check("mid_rst_pulse", rd, 0);
    check("mid_rst_pins2", 32'(PINS), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
